// File: rtl/alu_seq_if.sv
// Issue/response bundle between the control FSM and alu_seq.
// master drives the operation request; slave returns status, result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             dbg_state;

  // Handshake: start is accepted on a rising edge only while busy = 0;
  // done is a one-cycle pulse marking the cycle result/flags were updated,
  // busy and done are never high together, and start may be raised in the
  // done cycle for back-to-back issue.
  modport master (
    output start, alu_op, op1, op2, carry_in,
    input  busy, done, result, flags, dbg_state
  );

  modport slave (
    input  start, alu_op, op1, op2, carry_in,
    output busy, done, result, flags, dbg_state
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flags {Z,N,C,V} and an iterative shift-add unsigned
// multiply; single-cycle ops complete in one clock, MUL takes WIDTH clocks.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MEM = 4'd0;
  localparam logic [3:0] OP_IMM = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SUC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_LSL = 4'd9;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_NOP = 4'd13;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               done_q;
  logic               busy_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH:0]     a_ext, b_ext, arith;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v, is_add, is_sub, is_mul;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle datapath; arithmetic runs at WIDTH+1 bits so bit WIDTH is C.
  always_comb begin
    a_ext  = {1'b0, bus.op1};
    b_ext  = {1'b0, bus.op2};
    arith  = '0;
    sc_res = bus.op1;
    sc_c   = 1'b0;
    is_add = 1'b0;
    is_sub = 1'b0;
    is_mul = MUL_EN && (bus.alu_op == OP_MUL);
    case (bus.alu_op)
      OP_MEM: sc_res = bus.op1;
      OP_IMM: sc_res = bus.op2;
      OP_ADD: begin
        arith  = a_ext + b_ext;
        is_add = 1'b1;
      end
      OP_ADC: begin
        arith  = a_ext + b_ext + {{WIDTH{1'b0}}, bus.carry_in};
        is_add = 1'b1;
      end
      OP_SUB: begin
        arith  = a_ext - b_ext;
        is_sub = 1'b1;
      end
      OP_SUC: begin
        arith  = a_ext - b_ext - {{WIDTH{1'b0}}, ~bus.carry_in};
        is_sub = 1'b1;
      end
      OP_AND: sc_res = bus.op1 & bus.op2;
      OP_OR:  sc_res = bus.op1 | bus.op2;
      OP_NOT: sc_res = ~bus.op1;
      OP_LSL: begin
        sc_res = {bus.op1[MSB-1:0], 1'b0};
        sc_c   = bus.op1[MSB];
      end
      OP_LSR: begin
        sc_res = {1'b0, bus.op1[MSB:1]};
        sc_c   = bus.op1[0];
      end
      OP_ASR: begin
        sc_res = {bus.op1[MSB], bus.op1[MSB:1]};
        sc_c   = bus.op1[0];
      end
      OP_NOP: sc_res = '0;
      default: sc_res = bus.op1;
    endcase
    if (is_add || is_sub) begin
      sc_res = arith[WIDTH-1:0];
      sc_c   = arith[WIDTH];
    end
    if (is_add)
      sc_v = (bus.op1[MSB] == bus.op2[MSB]) && (sc_res[MSB] != bus.op1[MSB]);
    else if (is_sub)
      sc_v = (bus.op1[MSB] != bus.op2[MSB]) && (sc_res[MSB] != bus.op1[MSB]);
    else
      sc_v = 1'b0;
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      result_q <= '0;
      flags_q  <= 4'b1000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, bus.op1};
              mplier <= bus.op2;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              busy_q <= 1'b1;
              state  <= S_MUL;
            end else begin
              result_q <= sc_res;
              flags_q  <= {(sc_res == '0), sc_res[MSB], sc_c, sc_v};
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Last step: acc_nxt already holds the full product.
          if (cnt == CW'(1)) begin
            result_q <= acc_nxt[WIDTH-1:0];
            flags_q  <= {(acc_nxt[WIDTH-1:0] == '0), acc_nxt[MSB],
                         (acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): vector table streamed back-to-back, plus
// hand sequences for MUL timing, start-while-busy and reset mid-MUL.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t tbl[$];
  logic [W+3:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] er, input logic [3:0] ef,
                       input bit push);
    int guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue_wait_timeout", 1, 0);
    bus.alu_op   = op;
    bus.op1      = a;
    bus.op2      = b;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    if (push) exp_q.push_back({er, ef});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Scoreboard: every done pops one expected {result, flags}.
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (!rst && bus.done) begin
      check("busy_done_exclusive", bus.busy, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", bus.result, e[W+3:4]);
        check("sb_flags", bus.flags, e[3:0]);
      end
    end
  end

  initial begin
    int n;
    int nd;
    bus.start = 1'b0; bus.alu_op = '0; bus.op1 = '0; bus.op2 = '0; bus.carry_in = 1'b0;

    // flags are {Z,N,C,V}
    tbl.push_back('{4'd2,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101});
    tbl.push_back('{4'd4,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0110});
    tbl.push_back('{4'd5,  16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0000});
    tbl.push_back('{4'd5,  16'h0005, 16'h0003, 1'b1, 16'h0002, 4'b0000});
    tbl.push_back('{4'd10, 16'h0001, 16'h0000, 1'b0, 16'h0000, 4'b1010});
    tbl.push_back('{4'd11, 16'h8002, 16'h0000, 1'b0, 16'hC001, 4'b0100});
    tbl.push_back('{4'd9,  16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b1010});
    tbl.push_back('{4'd3,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1010});
    tbl.push_back('{4'd2,  16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1011});
    tbl.push_back('{4'd4,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001});
    tbl.push_back('{4'd4,  16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1000});
    tbl.push_back('{4'd6,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000});
    tbl.push_back('{4'd7,  16'hF000, 16'h000F, 1'b0, 16'hF00F, 4'b0100});
    tbl.push_back('{4'd8,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b0100});
    tbl.push_back('{4'd0,  16'h1234, 16'h5678, 1'b0, 16'h1234, 4'b0000});
    tbl.push_back('{4'd1,  16'h1234, 16'h5678, 1'b0, 16'h5678, 4'b0000});
    tbl.push_back('{4'd13, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b1000});
    tbl.push_back('{4'd14, 16'h8001, 16'h0000, 1'b0, 16'h8001, 4'b0100});
    tbl.push_back('{4'd15, 16'h0000, 16'h1111, 1'b0, 16'h0000, 4'b1000});
    tbl.push_back('{4'd10, 16'h8000, 16'h0000, 1'b0, 16'h4000, 4'b0000});
    tbl.push_back('{4'd11, 16'h0003, 16'h0000, 1'b0, 16'h0001, 4'b0010});

    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 4'b1000);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back stream: done must follow each start by one cycle.
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res, tbl[i].flg, 1'b1);
      check("lat1_done", bus.done, 1);
    end
    @(negedge clk);
    check("done_drops", bus.done, 0);
    repeat (3) @(negedge clk);
    check("hold_result", bus.result, 16'h0001);
    check("hold_flags", bus.flags, 4'b0010);

    // MUL timing: busy exactly 16 cycles, done as busy falls.
    issue(4'd12, 16'h0100, 16'h0101, 1'b0, 16'h0100, 4'b0010, 1'b1);
    check("mul_state_dbg", bus.dbg_state, 1);
    count_busy(n);
    check("mul_busy_cycles", n, 16);
    check("mul_done", bus.done, 1);
    check("mul_result", bus.result, 16'h0100);
    issue(4'd12, 16'h0003, 16'h0005, 1'b0, 16'h000F, 4'b0000, 1'b1);
    count_busy(n);
    check("mul2_busy_cycles", n, 16);
    check("mul2_result", bus.result, 16'h000F);

    // Start while busy is ignored; then issue ADD in the done cycle.
    issue(4'd12, 16'h0007, 16'h0009, 1'b0, 16'h003F, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    bus.alu_op = 4'd2; bus.op1 = 16'h0001; bus.op2 = 16'h0001; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    count_busy(n);
    check("hs_done", bus.done, 1);
    check("hs_mul_result", bus.result, 16'h003F);
    issue(4'd2, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1'b1);
    check("hs_add_done", bus.done, 1);
    check("hs_add_result", bus.result, 16'h0002);

    // Reset at MUL cycle 8 aborts without done.
    issue(4'd12, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0000, 1'b0);
    repeat (7) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_flags", bus.flags, 4'b1000);
    check("abort_state", bus.dbg_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("abort_no_done", nd, 0);
    issue(4'd12, 16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 4'b0100, 1'b1);
    count_busy(n);
    check("post_rst_busy_cycles", n, 16);
    check("post_rst_result", bus.result, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
